ts_out_scheduler: RTL

- Sits on the 27 MHz read side of the muxed-TS output FIFO and sequences all reads from it.
- Emits whole 188-byte packets only. At each packet boundary it takes a FIFO packet if one is fully buffered; otherwise it inserts a null packet, so the output rate stays constant.
- A fractional accumulator paces byte slots, giving a programmable output byterate for the ASI/parallel TS outputs.
- It also resynchronises to the psync flag and keeps statistics counters.

---
 rtl/ts_out_scheduler_pkg.sv | 27 ++
 rtl/ts_out_scheduler_rate_pacer.sv | 25 ++
 rtl/ts_out_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ts_out_scheduler_pkg.sv
// Shared constants, state encoding and null-packet byte lookup for the TS output scheduler.
package ts_out_scheduler_pkg;

  localparam int unsigned TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam logic [7:0]  NULL_FILL    = 8'hFF;

  // Null header in transmit order, byte 0 in the top lane: PID 0x1FFF, payload only, CC = 0
  localparam logic [3:0][7:0] NULL_HDR = {TS_SYNC_BYTE, 8'h1F, 8'hFF, 8'h10};

  typedef enum logic [1:0] {
    StIdle,
    StFifoPkt,
    StNullPkt,
    StResync
  } state_e;

  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    b = NULL_FILL;
    if (idx < 8'd4) begin
      b = NULL_HDR[2'd3 - idx[1:0]];
    end
    return b;
  endfunction

endpackage

// File: rtl/ts_out_scheduler_rate_pacer.sv
// Fractional accumulator: slot_o pulses at clk rate * rate_inc_i / 2^RateW.
module ts_out_scheduler_rate_pacer #(
  parameter int unsigned RateW = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [RateW-1:0] rate_inc_i,
  output logic             slot_o
);

  logic [RateW-1:0] acc_q, acc_d;

  always_comb begin
    {slot_o, acc_d} = {1'b0, acc_q} + {1'b0, rate_inc_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ts_out_scheduler.sv
// Paced whole-packet reader of the muxed-TS FIFO with null-packet stuffing, psync resync and stats.
module ts_out_scheduler
  import ts_out_scheduler_pkg::*;
#(
  parameter int unsigned PKT_LEN = TS_PKT_LEN,
  parameter int unsigned LVL_W   = 10,
  parameter int unsigned RATE_W  = 16
) (
  input  logic              clk_27,
  input  logic              RST,
  input  logic [8:0]        fifo_q,
  input  logic              fifo_empty,
  input  logic [LVL_W-1:0]  fifo_rdusedw,
  output logic              fifo_rdreq,
  input  logic [RATE_W-1:0] rate_inc,
  input  logic              null_ena,
  output logic [7:0]        data_out,
  output logic              d_valid_out,
  output logic              p_sync_out,
  output logic              underrun,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       null_cnt,
  output logic [15:0]       drop_cnt
);

  localparam logic [7:0]       LastIdx = 8'(PKT_LEN - 1);
  localparam logic [LVL_W-1:0] PktLvl  = LVL_W'(PKT_LEN);

  logic        slot;
  logic        emit_fifo, emit_null;
  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        psync_q, psync_d;
  logic        underrun_q, underrun_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] null_cnt_q, null_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  ts_out_scheduler_rate_pacer #(
    .RateW(RATE_W)
  ) u_pacer (
    .clk_i     (clk_27),
    .rst_ni    (RST),
    .rate_inc_i(rate_inc),
    .slot_o    (slot)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    psync_d    = 1'b0;
    underrun_d = underrun_q;
    pkt_cnt_d  = pkt_cnt_q;
    null_cnt_d = null_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_rdreq = 1'b0;
    emit_fifo  = 1'b0;
    emit_null  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (slot) begin
          if (!fifo_empty && !fifo_q[8]) begin
            state_d = StResync;
          end else if (!fifo_empty && (fifo_rdusedw >= PktLvl)) begin
            state_d   = StFifoPkt;
            emit_fifo = 1'b1;
          end else if (null_ena) begin
            state_d   = StNullPkt;
            emit_null = 1'b1;
          end
        end
      end
      StFifoPkt: begin
        if (slot) begin
          if (fifo_empty) begin
            underrun_d = 1'b1;
          end else begin
            emit_fifo = 1'b1;
          end
        end
      end
      StNullPkt: begin
        emit_null = slot;
      end
      StResync: begin
        // Not slot-gated: drain misaligned words as fast as the FIFO presents them
        if (!fifo_empty) begin
          if (!fifo_q[8]) begin
            fifo_rdreq = 1'b1;
            if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase

    if (emit_fifo || emit_null) begin
      valid_d    = 1'b1;
      psync_d    = (idx_q == 8'd0);
      data_d     = emit_fifo ? fifo_q[7:0] : null_byte(idx_q);
      fifo_rdreq = emit_fifo;
      if (idx_q == LastIdx) begin
        idx_d   = 8'd0;
        state_d = StIdle;
        if (emit_fifo) begin
          if (~&pkt_cnt_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
        end else begin
          if (~&null_cnt_q) null_cnt_d = null_cnt_q + 32'd1;
        end
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_27 or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      psync_q    <= 1'b0;
      underrun_q <= 1'b0;
      pkt_cnt_q  <= '0;
      null_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      psync_q    <= psync_d;
      underrun_q <= underrun_d;
      pkt_cnt_q  <= pkt_cnt_d;
      null_cnt_q <= null_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign data_out    = data_q;
  assign d_valid_out = valid_q;
  assign p_sync_out  = psync_q;
  assign underrun    = underrun_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign null_cnt    = null_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
